// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Optional build macro used by the fetch unit: IF_FETCH_PERF_EN.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_INC     = 32'd4;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    // Force an address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_next_pc.sv
// Next-PC selection: trap redirect beats branch redirect beats sequential PC.
// Redirect targets are word-aligned; the sequential PC wraps modulo 2^32.
module if_next_pc
    import if_fetch_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_trap_redirect,
    input  logic [31:0] i_trap_target,
    input  logic        i_branch_redirect,
    input  logic [31:0] i_branch_target,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_seq_pc
);

    // Priority mux for redirect target plus the sequential increment.
    always_comb begin
        o_redirect    = i_trap_redirect | i_branch_redirect;
        o_redirect_pc = align_word(i_branch_target);
        if (i_trap_redirect) begin
            o_redirect_pc = align_word(i_trap_target);
        end
        o_seq_pc = i_pc + PC_INC;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end and producer side of the IF/ID register.
// Issues one instruction-memory read at a time, discards responses made
// stale by a redirect, and holds the presented instruction until the hazard
// unit lets the PC advance (or a WFI hold is released).
// Optional build macro: IF_FETCH_PERF_EN adds fetch/stall event counters.
module if_fetch_unit
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_write,
    input  logic        branch_redirect,
    input  logic [31:0] branch_target,
    input  logic        trap_redirect,
    input  logic [31:0] trap_target,
    input  logic        WFI,
    input  logic        interrupt_pulse,
    output logic        im_req_valid,
    input  logic        im_req_ready,
    output logic [31:0] im_req_addr,
    input  logic        im_rsp_valid,
    input  logic [31:0] im_rsp_data,
    output logic [31:0] PC_out,
    output logic [31:0] PCadd4_Out,
    output logic [31:0] IM_Instruction,
    output logic        fetch_valid,
    output logic        stall
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic              r_fetch_valid;

    logic              w_redirect;
    logic [31:0]       w_redirect_pc;
    logic [31:0]       w_seq_pc;
    logic              w_wfi_hold;
    logic              w_fetch_done;
    logic              w_stall;

    if_next_pc u_next_pc (
        .i_pc              (r_pc),
        .i_trap_redirect   (trap_redirect),
        .i_trap_target     (trap_target),
        .i_branch_redirect (branch_redirect),
        .i_branch_target   (branch_target),
        .o_redirect        (w_redirect),
        .o_redirect_pc     (w_redirect_pc),
        .o_seq_pc          (w_seq_pc)
    );

    // Hold/stall decode: only a presented, non-WFI-held instruction lets IF/ID capture.
    always_comb begin
        w_wfi_hold   = WFI && !interrupt_pulse;
        w_fetch_done = (r_state == S_WAIT) && im_rsp_valid && !w_redirect;
        w_stall      = 1'b1;
        if (r_state == S_HOLD) begin
            w_stall = !w_redirect && w_wfi_hold;
        end
    end

    // Fetch FSM: owns the PC, the request handshake and the presented instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_fetch_valid <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_redirect) begin
                        r_pc <= w_redirect_pc;
                        // The old address was accepted, so its response must be swallowed.
                        r_state <= im_req_ready ? S_DROP : S_REQ;
                    end else if (im_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_redirect) begin
                        r_pc    <= w_redirect_pc;
                        r_state <= im_rsp_valid ? S_REQ : S_DROP;
                    end else if (w_fetch_done) begin
                        r_instr       <= im_rsp_data;
                        r_fetch_valid <= 1'b1;
                        r_state       <= S_HOLD;
                    end
                end
                S_DROP: begin
                    // Latest redirect wins; the pending response is discarded either way.
                    if (w_redirect) begin
                        r_pc <= w_redirect_pc;
                    end
                    if (im_rsp_valid) begin
                        r_state <= S_REQ;
                    end
                end
                S_HOLD: begin
                    if (w_redirect) begin
                        r_pc          <= w_redirect_pc;
                        r_fetch_valid <= 1'b0;
                        r_state       <= S_REQ;
                    end else if (w_wfi_hold) begin
                        r_state <= S_HOLD;
                    end else if (PC_write) begin
                        r_pc          <= w_seq_pc;
                        r_fetch_valid <= 1'b0;
                        r_state       <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_stall_cnt;

    // Event counters: completed fetches and stalled cycles, both free-running.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch_cnt <= 32'd0;
            r_perf_stall_cnt <= 32'd0;
        end else begin
            if (w_fetch_done) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            end
            if (w_stall) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch_cnt;
    assign perf_stall_cnt = r_perf_stall_cnt;
`endif

    assign im_req_valid   = (r_state == S_REQ);
    assign im_req_addr    = r_pc;
    assign PC_out         = r_pc;
    assign PCadd4_Out     = w_seq_pc;
    assign IM_Instruction = r_instr;
    assign fetch_valid    = r_fetch_valid;
    assign stall          = w_stall;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level model.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_write;
    logic        branch_redirect;
    logic [31:0] branch_target;
    logic        trap_redirect;
    logic [31:0] trap_target;
    logic        WFI;
    logic        interrupt_pulse;
    logic        im_req_valid;
    logic        im_req_ready;
    logic [31:0] im_req_addr;
    logic        im_rsp_valid;
    logic [31:0] im_rsp_data;
    logic [31:0] PC_out;
    logic [31:0] PCadd4_Out;
    logic [31:0] IM_Instruction;
    logic        fetch_valid;
    logic        stall;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RST_PC), .ADDR_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .PC_write        (PC_write),
        .branch_redirect (branch_redirect),
        .branch_target   (branch_target),
        .trap_redirect   (trap_redirect),
        .trap_target     (trap_target),
        .WFI             (WFI),
        .interrupt_pulse (interrupt_pulse),
        .im_req_valid    (im_req_valid),
        .im_req_ready    (im_req_ready),
        .im_req_addr     (im_req_addr),
        .im_rsp_valid    (im_rsp_valid),
        .im_rsp_data     (im_rsp_data),
        .PC_out          (PC_out),
        .PCadd4_Out      (PCadd4_Out),
        .IM_Instruction  (IM_Instruction),
        .fetch_valid     (fetch_valid),
        .stall           (stall)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    typedef struct {
        logic        pcw;
        logic        br;
        logic [31:0] bt;
        logic        tr;
        logic [31:0] tt;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_fv;
        logic        e_st;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t vec[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and return all inputs to idle.
    task automatic nx();
        @(negedge clk);
        rst             = 1'b0;
        PC_write        = 1'b0;
        branch_redirect = 1'b0;
        branch_target   = 32'd0;
        trap_redirect   = 1'b0;
        trap_target     = 32'd0;
        WFI             = 1'b0;
        interrupt_pulse = 1'b0;
        im_req_ready    = 1'b0;
        im_rsp_valid    = 1'b0;
        im_rsp_data     = 32'd0;
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Random-phase model state
    logic [31:0] m_pc;
    logic        m_fv;
    logic [31:0] m_data;
    logic        o_out;
    logic [31:0] o_addr;
    logic        o_stale;
    int          o_delay;
    int          npres;

    initial begin
        rst = 1'b1;
        PC_write = 1'b0; branch_redirect = 1'b0; branch_target = 32'd0;
        trap_redirect = 1'b0; trap_target = 32'd0; WFI = 1'b0; interrupt_pulse = 1'b0;
        im_req_ready = 1'b0; im_rsp_valid = 1'b0; im_rsp_data = 32'd0;

        //        pcw  br   bt            tr   tt            rdy  rv   rd              e_rv e_ra          e_fv e_st e_pc          e_ins
        vec[0]  = '{1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,32'h0,          1'b1,32'h0,        1'b0,1'b1,32'h0,        32'h0};
        vec[1]  = '{1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,32'h0000_0013,  1'b0,32'h0,        1'b0,1'b1,32'h0,        32'h0};
        vec[2]  = '{1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h0,          1'b0,32'h0,        1'b1,1'b0,32'h0,        32'h0000_0013};
        vec[3]  = '{1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,32'h0,          1'b1,32'h4,        1'b0,1'b1,32'h4,        32'h0};
        vec[4]  = '{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,32'hAAAA_0001,  1'b0,32'h0,        1'b0,1'b1,32'h4,        32'h0};
        vec[5]  = '{1'b1,1'b1,32'h300,      1'b1,32'h200,      1'b0,1'b0,32'h0,          1'b0,32'h0,        1'b1,1'b0,32'h4,        32'hAAAA_0001};
        vec[6]  = '{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h0,          1'b1,32'h200,      1'b0,1'b1,32'h200,      32'h0};
        vec[7]  = '{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,32'h0,          1'b1,32'h200,      1'b0,1'b1,32'h200,      32'h0};
        vec[8]  = '{1'b0,1'b1,32'h102,      1'b0,32'h0,        1'b0,1'b0,32'h0,          1'b0,32'h0,        1'b0,1'b1,32'h200,      32'h0};
        vec[9]  = '{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h0,          1'b0,32'h0,        1'b0,1'b1,32'h100,      32'h0};
        vec[10] = '{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,32'hDEAD_BEEF,  1'b0,32'h0,        1'b0,1'b1,32'h100,      32'h0};
        vec[11] = '{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,32'h0,          1'b1,32'h100,      1'b0,1'b1,32'h100,      32'h0};
        vec[12] = '{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,32'h0010_0093,  1'b0,32'h0,        1'b0,1'b1,32'h100,      32'h0};
        vec[13] = '{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h0,          1'b0,32'h0,        1'b1,1'b0,32'h100,      32'h0010_0093};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_pc", PC_out, RST_PC);
        chk("rst_pc4", PCadd4_Out, RST_PC + 32'd4);
        chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd1);
        chk("rst_instr", IM_Instruction, 32'd0);
        chk("rst_reqv", {31'd0, im_req_valid}, 32'd1);

        // Directed vector table: basic fetch, trap-over-branch, stale drop
        for (int i = 0; i < 14; i++) begin
            nx();
            PC_write = vec[i].pcw;
            branch_redirect = vec[i].br; branch_target = vec[i].bt;
            trap_redirect = vec[i].tr; trap_target = vec[i].tt;
            im_req_ready = vec[i].rdy; im_rsp_valid = vec[i].rv; im_rsp_data = vec[i].rd;
            #1;
            chk($sformatf("v%0d_reqv", i), {31'd0, im_req_valid}, {31'd0, vec[i].e_rv});
            if (vec[i].e_rv) chk($sformatf("v%0d_addr", i), im_req_addr, vec[i].e_ra);
            chk($sformatf("v%0d_fv", i), {31'd0, fetch_valid}, {31'd0, vec[i].e_fv});
            chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vec[i].e_st});
            chk($sformatf("v%0d_pc", i), PC_out, vec[i].e_pc);
            chk($sformatf("v%0d_pc4", i), PCadd4_Out, vec[i].e_pc + 32'd4);
            if (vec[i].e_fv) chk($sformatf("v%0d_ins", i), IM_Instruction, vec[i].e_ins);
        end

        // WFI hold for 10 cycles, then wake with a trap to 0x80
        for (int i = 0; i < 10; i++) begin
            nx(); PC_write = 1'b1; WFI = 1'b1; im_req_ready = 1'b1; #1;
            chk("wfi_stall", {31'd0, stall}, 32'd1);
            chk("wfi_reqv", {31'd0, im_req_valid}, 32'd0);
            chk("wfi_pc", PC_out, 32'h100);
        end
        nx(); WFI = 1'b1; interrupt_pulse = 1'b1; trap_redirect = 1'b1; trap_target = 32'h80; PC_write = 1'b1; #1;
        chk("wake_stall", {31'd0, stall}, 32'd0);
        nx(); im_req_ready = 1'b1; #1;
        chk("wake_reqv", {31'd0, im_req_valid}, 32'd1);
        chk("wake_addr", im_req_addr, 32'h80);
        nx(); im_rsp_valid = 1'b1; im_rsp_data = 32'h0000_0073; #1;

        // PC_write low holds the instruction, then advance to PC+4
        for (int i = 0; i < 4; i++) begin
            nx(); #1;
            chk("hold_pc", PC_out, 32'h80);
            chk("hold_reqv", {31'd0, im_req_valid}, 32'd0);
            chk("hold_ins", IM_Instruction, 32'h0000_0073);
            chk("hold_stall", {31'd0, stall}, 32'd0);
        end
        nx(); PC_write = 1'b1; #1;
        nx(); im_req_ready = 1'b1; #1;
        chk("adv_addr", im_req_addr, 32'h84);
        nx(); im_rsp_valid = 1'b1; im_rsp_data = 32'h1111_1111; #1;

        // Unaligned trap target near the top of memory, then wrap to 0
        nx(); trap_redirect = 1'b1; trap_target = 32'hFFFF_FFFF; #1;
        chk("top_ins", IM_Instruction, 32'h1111_1111);
        nx(); im_req_ready = 1'b1; #1;
        chk("align_addr", im_req_addr, 32'hFFFF_FFFC);
        nx(); im_rsp_valid = 1'b1; im_rsp_data = 32'h2222_2222; #1;
        nx(); PC_write = 1'b1; #1;
        chk("wrap_pc4", PCadd4_Out, 32'h0);
        chk("wrap_fv", {31'd0, fetch_valid}, 32'd1);
        nx(); im_req_ready = 1'b1; #1;
        chk("wrap_addr", im_req_addr, 32'h0);

        // Reset while waiting; the late response must be ignored
        nx(); rst = 1'b1; #1;
        chk("wait_stall", {31'd0, stall}, 32'd1);
        nx(); im_rsp_valid = 1'b1; im_rsp_data = 32'h3333_3333; #1;
        chk("late_reqv", {31'd0, im_req_valid}, 32'd1);
        chk("late_addr", im_req_addr, RST_PC);
        chk("late_ins", IM_Instruction, 32'd0);
        nx(); #1;
        chk("late_fv", {31'd0, fetch_valid}, 32'd0);
        chk("late_reqv2", {31'd0, im_req_valid}, 32'd1);

        // Randomized traffic against a transaction-level model
        m_pc = RST_PC; m_fv = 1'b0; m_data = 32'd0;
        o_out = 1'b0; o_addr = 32'd0; o_stale = 1'b0; o_delay = 0; npres = 0;
        for (int c = 0; c < 3000; c++) begin
            logic redir, wfih, rspnow;
            logic [31:0] tgt;
            int r;
            nx();
            rst = ($urandom_range(0, 299) == 0);
            r = $urandom_range(0, 99);
            trap_redirect   = (r < 4);
            branch_redirect = (r < 2) || (r >= 4 && r < 12);
            trap_target     = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            branch_target   = $urandom;
            WFI             = ($urandom_range(0, 3) == 0);
            interrupt_pulse = ($urandom_range(0, 7) == 0);
            PC_write        = ($urandom_range(0, 9) < 7);
            im_req_ready    = rst ? 1'b0 : ($urandom_range(0, 9) < 6);
            rspnow          = o_out && (o_delay == 0);
            im_rsp_valid    = rspnow;
            im_rsp_data     = rspnow ? memf(o_addr) : $urandom;
            #1;
            redir = trap_redirect || branch_redirect;
            wfih  = WFI && !interrupt_pulse;
            tgt   = (trap_redirect ? trap_target : branch_target) & 32'hFFFF_FFFC;
            chk("rnd_pc", PC_out, m_pc);
            chk("rnd_pc4", PCadd4_Out, m_pc + 32'd4);
            chk("rnd_fv", {31'd0, fetch_valid}, {31'd0, m_fv});
            if (m_fv) chk("rnd_ins", IM_Instruction, m_data);
            chk("rnd_stall", {31'd0, stall}, {31'd0, m_fv ? (!redir && wfih) : 1'b1});
            chk("rnd_reqv", {31'd0, im_req_valid}, {31'd0, !m_fv && !o_out});
            if (!m_fv && !o_out) chk("rnd_addr", im_req_addr, m_pc);

            if (rst) begin
                m_pc = RST_PC; m_fv = 1'b0; o_out = 1'b0;
            end else begin
                logic presented, accept;
                presented = m_fv;
                accept = im_req_valid && im_req_ready;
                if (o_out) begin
                    if (rspnow) begin
                        o_out = 1'b0;
                        if (!o_stale && !redir) begin
                            m_fv = 1'b1; m_data = memf(o_addr); npres++;
                        end
                    end else begin
                        o_delay--;
                        if (redir) o_stale = 1'b1;
                    end
                end
                if (accept) begin
                    o_out = 1'b1; o_addr = m_pc; o_stale = redir;
                    o_delay = $urandom_range(0, 3);
                end
                if (presented && (redir || (!wfih && PC_write))) m_fv = 1'b0;
                if (redir) m_pc = tgt;
                else if (presented && !wfih && PC_write) m_pc = m_pc + 32'd4;
            end
        end
        chk("rnd_progress", {31'd0, (npres >= 100)}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
